// File: rtl/br_pred_pkg.sv
// Shared types and helpers for the bimodal predictor: 2-bit counter states,
// saturating update, and PC -> index/tag slicing for a given index width.
package br_pred_pkg;

  localparam int CTR_W = 2;

  typedef enum logic [CTR_W-1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  function automatic ctr_e sat_next(input ctr_e cur, input logic taken);
    ctr_e nxt;
    nxt = cur;
    case (cur)
      SNT: nxt = taken ? WNT : SNT;
      WNT: nxt = taken ? WT  : SNT;
      WT:  nxt = taken ? ST  : WNT;
      ST:  nxt = taken ? ST  : WT;
      default: nxt = cur;
    endcase
    return nxt;
  endfunction

  // Instructions are word aligned, so the index starts at bit 2.
  function automatic logic [31:0] idx_of(input logic [31:0] pc, input int idx_w);
    logic [31:0] mask;
    mask = (32'd1 << idx_w) - 32'd1;
    return (pc >> 2) & mask;
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] pc, input int idx_w);
    return pc >> (idx_w + 2);
  endfunction

endpackage

// File: rtl/br_pred_btb.sv
// Direct-mapped branch target buffer: valid/tag/target arrays with one
// combinational read port (tag compare included) and one synchronous write port.
module br_pred_btb
  import br_pred_pkg::*;
#(
  parameter int IDX_W = 6,
  parameter int TAG_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  input  logic [TAG_W-1:0] rd_tag,
  output logic             rd_hit,
  output logic [31:0]      rd_tgt,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [31:0]      wr_tgt
);

  localparam int DEPTH = 1 << IDX_W;

  logic             valid [DEPTH];
  logic [TAG_W-1:0] tag   [DEPTH];
  logic [31:0]      tgt   [DEPTH];

  // Read returns the pre-write contents when rd_idx == wr_idx in the same cycle.
  assign rd_hit = valid[rd_idx] & (tag[rd_idx] == rd_tag);
  assign rd_tgt = tgt[rd_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid[i] <= 1'b0;
        tag[i]   <= '0;
        tgt[i]   <= '0;
      end
    end else if (wr_en) begin
      valid[wr_idx] <= 1'b1;
      tag[wr_idx]   <= wr_tag;
      tgt[wr_idx]   <= wr_tgt;
    end
  end

endmodule

// File: rtl/br_pred_bimodal.sv
// Bimodal branch predictor: per-index 2-bit counters gated by a direct-mapped BTB,
// trained at execute, with registered is_br/is_correct pulses for the scoreboard.
module br_pred_bimodal
  import br_pred_pkg::*;
#(
  parameter int         IDX_W   = 6,
  parameter logic [1:0] CTR_RST = 2'b01
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_f_pc,
  output logic        o_f_taken,
  output logic [31:0] o_f_target,
  input  logic        i_ex_valid,
  input  logic        i_ex_is_br,
  input  logic [31:0] i_ex_pc,
  input  logic        i_ex_taken,
  input  logic [31:0] i_ex_target,
  input  logic        i_ex_pred_taken,
  input  logic [31:0] i_ex_pred_target,
  output logic        o_is_br,
  output logic        o_is_correct,
  output logic        o_mispredict
);

  localparam int DEPTH = 1 << IDX_W;
  localparam int TAG_W = 30 - IDX_W;

  logic [IDX_W-1:0] f_idx, ex_idx;
  logic [TAG_W-1:0] f_tag, ex_tag;
  logic             btb_hit;
  logic [1:0]       f_ctr;
  logic             res;
  logic             correct;

  ctr_e ctr [DEPTH];

  assign f_idx  = IDX_W'(idx_of(i_f_pc, IDX_W));
  assign f_tag  = TAG_W'(tag_of(i_f_pc, IDX_W));
  assign ex_idx = IDX_W'(idx_of(i_ex_pc, IDX_W));
  assign ex_tag = TAG_W'(tag_of(i_ex_pc, IDX_W));

  assign res     = i_ex_valid & i_ex_is_br;
  // Target only matters when the branch was actually taken.
  assign correct = (i_ex_pred_taken == i_ex_taken) &
                   (~i_ex_taken | (i_ex_pred_target == i_ex_target));
  assign o_mispredict = res & ~correct;

  br_pred_btb #(
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_btb (
    .clk    (i_clk),
    .rst    (i_rst),
    .rd_idx (f_idx),
    .rd_tag (f_tag),
    .rd_hit (btb_hit),
    .rd_tgt (o_f_target),
    .wr_en  (res & i_ex_taken),
    .wr_idx (ex_idx),
    .wr_tag (ex_tag),
    .wr_tgt (i_ex_target)
  );

  assign f_ctr     = ctr[f_idx];
  assign o_f_taken = f_ctr[1] & btb_hit;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        ctr[i] <= ctr_e'(CTR_RST);
      end
    end else if (res) begin
      ctr[ex_idx] <= sat_next(ctr[ex_idx], i_ex_taken);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_is_br      <= 1'b0;
      o_is_correct <= 1'b0;
    end else begin
      o_is_br      <= res;
      o_is_correct <= res & correct;
    end
  end

endmodule

// File: tb/tb_br_pred_bimodal.sv
// Bench for br_pred_bimodal: array-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_br_pred_bimodal;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [31:0] i_f_pc;
  logic        o_f_taken;
  logic [31:0] o_f_target;
  logic        i_ex_valid;
  logic        i_ex_is_br;
  logic [31:0] i_ex_pc;
  logic        i_ex_taken;
  logic [31:0] i_ex_target;
  logic        i_ex_pred_taken;
  logic [31:0] i_ex_pred_target;
  logic        o_is_br;
  logic        o_is_correct;
  logic        o_mispredict;

  br_pred_bimodal #(.IDX_W(6), .CTR_RST(2'b01)) dut (
    .i_clk            (i_clk),
    .i_rst            (i_rst),
    .i_f_pc           (i_f_pc),
    .o_f_taken        (o_f_taken),
    .o_f_target       (o_f_target),
    .i_ex_valid       (i_ex_valid),
    .i_ex_is_br       (i_ex_is_br),
    .i_ex_pc          (i_ex_pc),
    .i_ex_taken       (i_ex_taken),
    .i_ex_target      (i_ex_target),
    .i_ex_pred_taken  (i_ex_pred_taken),
    .i_ex_pred_target (i_ex_pred_target),
    .o_is_br          (o_is_br),
    .o_is_correct     (o_is_correct),
    .o_mispredict     (o_mispredict)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;
  int n_br   = 0;
  int n_cor  = 0;
  logic chk_en = 1'b0;

  // Reference model: 64 entries, counters as plain integers 0..3.
  int          m_ctr [64];
  logic        m_v   [64];
  int unsigned m_tag [64];
  logic [31:0] m_tgt [64];
  logic        exp_br  = 1'b0;
  logic        exp_cor = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int midx(input logic [31:0] pc);
    return int'((pc / 4) % 64);
  endfunction

  function automatic logic model_pred(input logic [31:0] pc);
    int k;
    k = midx(pc);
    return (m_ctr[k] >= 2) && m_v[k] && (m_tag[k] == (pc / 256));
  endfunction

  function automatic logic model_correct();
    return (i_ex_pred_taken == i_ex_taken) &&
           (!i_ex_taken || (i_ex_pred_target == i_ex_target));
  endfunction

  always @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < 64; i++) begin
        m_ctr[i] = 1; m_v[i] = 1'b0; m_tag[i] = 0; m_tgt[i] = 32'h0;
      end
      exp_br  = 1'b0;
      exp_cor = 1'b0;
    end else begin
      exp_br  = i_ex_valid && i_ex_is_br;
      exp_cor = exp_br && model_correct();
      if (exp_br) begin
        int k;
        k = midx(i_ex_pc);
        if (i_ex_taken) begin
          if (m_ctr[k] < 3) m_ctr[k]++;
          m_v[k]   = 1'b1;
          m_tag[k] = i_ex_pc / 256;
          m_tgt[k] = i_ex_target;
        end else if (m_ctr[k] > 0) begin
          m_ctr[k]--;
        end
      end
    end
  end

  always @(negedge i_clk) begin
    if (chk_en) begin
      logic p;
      p = model_pred(i_f_pc);
      chk("f_taken", {31'b0, o_f_taken}, {31'b0, p});
      if (p) chk("f_target", o_f_target, m_tgt[midx(i_f_pc)]);
      chk("mispredict", {31'b0, o_mispredict},
          {31'b0, i_ex_valid && i_ex_is_br && !model_correct()});
      chk("is_br", {31'b0, o_is_br}, {31'b0, exp_br});
      chk("is_correct", {31'b0, o_is_correct}, {31'b0, exp_cor});
      if (o_is_br) n_br++;
      if (o_is_correct) n_cor++;
    end
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic br, input logic [31:0] pc, input logic t,
                       input logic [31:0] tgt, input logic pt, input logic [31:0] ptgt);
    i_ex_valid = v; i_ex_is_br = br; i_ex_pc = pc; i_ex_taken = t;
    i_ex_target = tgt; i_ex_pred_taken = pt; i_ex_pred_target = ptgt;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic fetch_chk(input string name, input logic [31:0] pc, input logic exp_t);
    i_f_pc = pc;
    #1;
    chk(name, {31'b0, o_f_taken}, {31'b0, exp_t});
  endtask

  initial begin
    i_rst = 1'b1;
    i_f_pc = 32'h0;
    idle();
    step();
    chk_en = 1'b1;
    step();
    i_rst = 1'b0;
    chk("rst_is_br", {31'b0, o_is_br}, 32'd0);
    chk("rst_is_correct", {31'b0, o_is_correct}, 32'd0);
    for (int pc = 0; pc <= 'hFC; pc += 4) fetch_chk("rst_sweep", 32'(pc), 1'b0);

    // Training: two taken resolves with a not-taken prediction, fetch watching 0x100.
    step();
    i_f_pc = 32'h100;
    for (int n = 0; n < 2; n++) begin
      drive(1'b1, 1'b1, 32'h100, 1'b1, 32'h140, 1'b0, 32'h0);
      #1;
      chk("train_mispredict", {31'b0, o_mispredict}, 32'd1);
      step();
      chk("train_is_br", {31'b0, o_is_br}, 32'd1);
      chk("train_is_correct", {31'b0, o_is_correct}, 32'd0);
    end
    idle();
    fetch_chk("train_taken", 32'h100, 1'b1);
    chk("train_target", o_f_target, 32'h140);

    // Saturation and hysteresis.
    for (int n = 0; n < 5; n++) begin
      drive(1'b1, 1'b1, 32'h100, 1'b1, 32'h140, 1'b1, 32'h140);
      step();
    end
    idle();
    chk("model_ctr_st", 32'(m_ctr[0]), 32'd3);
    drive(1'b1, 1'b1, 32'h100, 1'b0, 32'h0, 1'b1, 32'h140);
    step();
    idle();
    fetch_chk("hyst_one_nt", 32'h100, 1'b1);
    drive(1'b1, 1'b1, 32'h100, 1'b0, 32'h0, 1'b1, 32'h140);
    step();
    idle();
    fetch_chk("hyst_two_nt", 32'h100, 1'b0);
    chk("model_ctr_wnt", 32'(m_ctr[0]), 32'd1);

    // Alias: 0x200 shares index 0 with 0x100 but has a different tag.
    drive(1'b1, 1'b1, 32'h100, 1'b1, 32'h140, 1'b0, 32'h0);
    step();
    idle();
    fetch_chk("alias_0x200", 32'h200, 1'b0);
    fetch_chk("alias_0x100", 32'h100, 1'b1);

    // Target mismatch.
    drive(1'b1, 1'b1, 32'h100, 1'b1, 32'h180, 1'b1, 32'h140);
    #1;
    chk("tgt_mispredict", {31'b0, o_mispredict}, 32'd1);
    step();
    idle();
    chk("tgt_is_correct", {31'b0, o_is_correct}, 32'd0);
    fetch_chk("tgt_taken", 32'h100, 1'b1);
    chk("tgt_new_target", o_f_target, 32'h180);

    // Invalid execute slot must neither pulse nor train.
    step();
    drive(1'b0, 1'b1, 32'h5C0, 1'b1, 32'h600, 1'b0, 32'h0);
    step();
    idle();
    chk("invalid_no_pulse", {31'b0, o_is_br}, 32'd0);
    fetch_chk("invalid_no_update", 32'h5C0, 1'b0);

    // Pulse stream: 10 back-to-back resolves, entries 2, 5, 8 mispredicted.
    step();
    n_br = 0;
    n_cor = 0;
    for (int i = 0; i < 10; i++) begin
      logic t;
      logic wrong;
      t = logic'(i % 2);
      wrong = (i == 2) || (i == 5) || (i == 8);
      drive(1'b1, 1'b1, 32'h404 + 32'(4 * i), t, 32'h1000 + 32'(16 * i),
            wrong ? !t : t, 32'h1000 + 32'(16 * i));
      step();
    end
    idle();
    step();
    step();
    chk("stream_br_count", 32'(n_br), 32'd10);
    chk("stream_correct_count", 32'(n_cor), 32'd7);

    // Reset in a resolve cycle wins.
    i_rst = 1'b1;
    drive(1'b1, 1'b1, 32'h5C0, 1'b1, 32'h600, 1'b1, 32'h600);
    step();
    i_rst = 1'b0;
    idle();
    chk("rst_resolve_no_pulse", {31'b0, o_is_br}, 32'd0);
    fetch_chk("rst_resolve_no_update", 32'h5C0, 1'b0);
    fetch_chk("rst_clears_0x100", 32'h100, 1'b0);
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/br_pred_bimodal.md
# br_pred_bimodal

Bimodal branch predictor with a direct-mapped branch target buffer. It sits between fetch and execute. At fetch it supplies a same-cycle taken/target prediction for the current PC. At execute it receives the resolved outcome and trains its tables. For each resolved conditional branch it emits registered `o_is_br`/`o_is_correct` pulses, which feed the branch-prediction scoreboard counters.

## Interface
- `IDX_W`, 6: table index width; 2**IDX_W entries, indexed by `pc[IDX_W+1:2]`.
- `CTR_RST`, 2'b01: reset value of every 2-bit counter (weakly not-taken).
- `i_clk` input 1: clock, all state on rising edge.
- `i_rst` input 1: reset, synchronous and active-high.
- `i_f_pc` input 32: fetch PC.
- `o_f_taken` output 1: predicted taken; combinational from `i_f_pc`.
- `o_f_target` output 32: predicted target; valid when `o_f_taken`.
- `i_ex_valid` input 1: execute-stage instruction valid (not bubble/flushed).
- `i_ex_is_br` input 1: instruction is a conditional branch.
- `i_ex_pc` input 32: PC of resolving instruction.
- `i_ex_taken` input 1: actual direction.
- `i_ex_target` input 32: actual taken target.
- `i_ex_pred_taken` input 1: prediction made at fetch, carried down the pipe.
- `i_ex_pred_target` input 32: predicted target carried down the pipe.
- `o_is_br` output 1: registered pulse, one resolved branch.
- `o_is_correct` output 1: registered, prediction correct for that branch; 0 when `o_is_br`=0.
- `o_mispredict` output 1: combinational redirect request for the current resolve cycle.

## Operation
- Resolve event: `res = i_ex_valid & i_ex_is_br`. Jumps (JAL/JALR) are not tracked.
- Prediction lookup:
  - idx = `pc[IDX_W+1:2]`; tag = `pc[31:IDX_W+2]`.
  - `o_f_taken` = `ctr[idx][1] & btb_v[idx] & (btb_tag[idx]==tag)`.
  - `o_f_target` = `btb_tgt[idx]`.
- Correctness: `correct = (i_ex_pred_taken==i_ex_taken) & (~i_ex_taken | i_ex_pred_target==i_ex_target)`.
- `o_mispredict = res & ~correct`.
- Counter update on `res`: saturating; taken increments and saturates at 2'b11; not-taken decrements and saturates at 2'b00.
- BTB update on `res & i_ex_taken`: write v=1, tag and target. A not-taken branch leaves its BTB entry unchanged.
- Aliasing: PCs sharing an idx share a counter. A BTB tag mismatch forces a not-taken prediction.
- Same-index fetch read and resolve write in one cycle: fetch sees the pre-update value (no bypass).
- Reset:
  - Every counter = `CTR_RST`; every `btb_v` = 0; `btb_tag`/`btb_tgt` = 0.
  - `o_is_br` = 0, `o_is_correct` = 0.
  - Post-reset `o_f_taken` = 0 for every PC.
- Reset asserted in a resolve cycle: the reset wins, and there is no table update and no pulse.

## Timing
- Fetch prediction: 0-cycle combinational lookup.
- Training: the table update is visible to a fetch lookup in cycle N+1 after a resolve in cycle N.
- `o_is_br`/`o_is_correct`: registered, asserted in cycle N+1 for exactly one cycle per resolve.
- Back-to-back resolves in consecutive cycles are accepted every cycle and produce consecutive pulses.
- `o_mispredict`: same cycle as the resolve, no register.

## Structure
- Package `br_pred_pkg`:
  - `ctr_e` enum: `SNT`=2'b00, `WNT`=2'b01, `WT`=2'b10, `ST`=2'b11.
  - Function `sat_next(ctr_e, taken)`.
  - Functions `idx_of(pc)` and `tag_of(pc)`, parameterised by `IDX_W`.
- Sub-module `br_pred_btb`: valid/tag/target arrays with one combinational read port and one synchronous write port.
- Counter array and correctness/pulse logic stay in the top module.

## Test plan
- Reset: assert `i_rst` 2 cycles; sweep `i_f_pc` 0x0 to 0xFC step 4 -> `o_f_taken`=0 everywhere, `o_is_br`=0.
- Training: branch at 0x100, taken, target 0x140, resolved twice (pred=0 each time) -> `o_is_correct`=0 both times, `o_mispredict` high in both resolve cycles; next fetch of 0x100 -> `o_f_taken`=1, `o_f_target`=0x140.
- Saturation and hysteresis:
  - Resolve 0x100 taken 5x -> counter at `ST`.
  - Then one not-taken resolve -> still predicts taken.
  - A second not-taken resolve -> predicts not-taken.
- Alias/tag: train 0x100 taken; fetch 0x200 (same idx with `IDX_W`=6, different tag) -> `o_f_taken`=0.
- Target mismatch: pred_taken=1, pred_target=0x140, actual taken to 0x180 -> `o_is_correct`=0, BTB target becomes 0x180.
- Pulse stream:
  - 10 consecutive resolves, 7 correct -> exactly 10 `o_is_br` and 7 `o_is_correct` pulses, each one cycle late.
  - `i_ex_valid`=0 with `i_ex_is_br`=1 -> no pulse and no update.
  - `i_rst` in a resolve cycle -> no pulse.
